// File: rtl/sqwave_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sqwave_pkg                                            |
// | Purpose  : Shared types and constants for the square-wave step   |
// |            sequencer: FSM state encoding, step-entry field       |
// |            layout and the default clock-to-unit ratio.           |
// | Ports    : none (package)                                        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package sqwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_NEXT = 3'd4
  } state_e;

  // Step entry layout: {rep[15:8], m[7:4], n[3:0]}
  localparam int ENTRY_W = 16;
  localparam int REP_MSB = 15;
  localparam int REP_LSB = 8;
  localparam int M_MSB   = 7;
  localparam int M_LSB   = 4;
  localparam int N_MSB   = 3;
  localparam int N_LSB   = 0;

  // 50 MHz clock, 100 ns unit
  localparam int TICKS_PER_UNIT_DEF = 5;

endpackage
`default_nettype wire

// File: rtl/sqwave_period.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sqwave_period                                         |
// | Purpose  : Times one square-wave period: m units high followed   |
// |            by n units low (either phase may be zero length).     |
// |            Restarts itself immediately after each period, so     |
// |            back-to-back repetitions have no gap.                 |
// | Ports    : clk, rst_n     clock / async active-low reset         |
// |            load           start a fresh period (uses m,n now)    |
// |            m, n           high / low length in units             |
// |            phase_hi       phase the generator is in NEXT cycle   |
// |            period_done    last cycle of the current period       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module sqwave_period
  import sqwave_pkg::*;
#(
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] m,
  input  logic [3:0] n,
  output logic       phase_hi,
  output logic       period_done
);

  localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);

  logic          hi_q, hi_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    unit_q, unit_d;
  logic [3:0]    cur_units;
  logic          tick_last;
  logic          phase_end;

  always_comb begin
    cur_units   = hi_q ? m : n;
    tick_last   = (tick_q == TICK_LAST);
    phase_end   = tick_last && (unit_q == cur_units - 4'd1);
    hi_d        = hi_q;
    tick_d      = tick_last ? '0 : tick_q + 1'b1;
    unit_d      = tick_last ? unit_q + 4'd1 : unit_q;
    period_done = 1'b0;
    if (phase_end) begin
      tick_d = '0;
      unit_d = '0;
      if (hi_q && (n != 4'd0)) begin
        hi_d = 1'b0;
      end else begin
        // Period complete: wrap straight into the next repetition.
        period_done = 1'b1;
        hi_d        = (m != 4'd0);
      end
    end
    if (load) begin
      tick_d = '0;
      unit_d = '0;
      hi_d   = (m != 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= 1'b0;
      tick_q <= '0;
      unit_q <= '0;
    end else begin
      hi_q   <= hi_d;
      tick_q <= tick_d;
      unit_q <= unit_d;
    end
  end

  // The sequencer registers this into its own state so its HIGH/LOW
  // state lines up exactly with the generator's phase.
  assign phase_hi = hi_d;

endmodule
`default_nettype wire

// File: rtl/sqwave_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sqwave_sequencer                                      |
// | Purpose  : Plays a programmed table of square-wave steps         |
// |            {rep, m, n}: rep periods of m units high then n units |
// |            low. One-shot or looping playback, abort, done pulse. |
// | Ports    : clk, rst_n     clock / async active-low reset         |
// |            wr_en/addr/data table write (honoured only when idle) |
// |            len, loop      step count / wrap mode, sampled at start|
// |            start, stop    start pulse / abort pulse              |
// |            out            registered square-wave output          |
// |            busy, step_idx playback active / current step         |
// |            done           1-cycle pulse at end of one-shot run   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module sqwave_sequencer
  import sqwave_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [15:0]                wr_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       loop,
  input  logic                       start,
  input  logic                       stop,
  output logic                       out,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);

  // Step table has no reset: contents survive rst_n.
  logic [ENTRY_W-1:0] tbl_q [DEPTH];

  state_e          state_q, state_d;
  logic [AW-1:0]   step_idx_q, step_idx_d;
  logic [AW:0]     len_q, len_d;
  logic            loop_q, loop_d;
  logic [7:0]      rep_cnt_q, rep_cnt_d;
  logic [3:0]      m_q, m_d, n_q, n_d;
  logic            out_q, out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [ENTRY_W-1:0] entry;
  logic [7:0]         e_rep;
  logic [3:0]         e_m, e_n;
  logic               per_load, per_hi, per_done;
  logic [3:0]         per_m, per_n;

  assign entry = tbl_q[step_idx_q];
  assign e_rep = entry[REP_MSB:REP_LSB];
  assign e_m   = entry[M_MSB:M_LSB];
  assign e_n   = entry[N_MSB:N_LSB];

  // During LOAD the generator must see the entry being latched.
  assign per_m = (state_q == ST_LOAD) ? e_m : m_q;
  assign per_n = (state_q == ST_LOAD) ? e_n : n_q;

  sqwave_period #(
    .TICKS_PER_UNIT (TICKS_PER_UNIT)
  ) u_period (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (per_load),
    .m           (per_m),
    .n           (per_n),
    .phase_hi    (per_hi),
    .period_done (per_done)
  );

  always_ff @(posedge clk) begin
    if (wr_en && (state_q == ST_IDLE)) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    len_d      = len_q;
    loop_d     = loop_q;
    rep_cnt_d  = rep_cnt_q;
    m_d        = m_q;
    n_d        = n_q;
    done_d     = 1'b0;
    per_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (len != '0) begin
            state_d    = ST_LOAD;
            step_idx_d = '0;
            len_d      = len;
            loop_d     = loop;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        rep_cnt_d = e_rep;
        m_d       = e_m;
        n_d       = e_n;
        if ((e_rep == 8'd0) || ((e_m == 4'd0) && (e_n == 4'd0))) begin
          state_d = ST_NEXT;
        end else begin
          per_load = 1'b1;
          state_d  = (e_m != 4'd0) ? ST_HIGH : ST_LOW;
        end
      end
      ST_HIGH, ST_LOW: begin
        if (per_done && (rep_cnt_q == 8'd1)) begin
          state_d = ST_NEXT;
        end else begin
          if (per_done) begin
            rep_cnt_d = rep_cnt_q - 8'd1;
          end
          state_d = per_hi ? ST_HIGH : ST_LOW;
        end
      end
      ST_NEXT: begin
        if ({1'b0, step_idx_q} == len_q - 1'b1) begin
          if (loop_q) begin
            step_idx_d = '0;
            state_d    = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          step_idx_d = step_idx_q + 1'b1;
          state_d    = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything and never produces done.
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_idx_q <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      rep_cnt_q  <= '0;
      m_q        <= '0;
      n_q        <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      rep_cnt_q  <= rep_cnt_d;
      m_q        <= m_d;
      n_q        <= n_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign step_idx = step_idx_q;
  assign done     = done_q;

endmodule
`default_nettype wire
